// File: rtl/a5_keystream_buffer.sv
// -----------------------------------------------------------------------------
// a5_keystream_buffer
//
// A5/1 keystream generator feeding a small word FIFO. A load pulse captures the
// session key and frame number into shadow registers and runs the A5/1
// schedule: 64 key steps, 22 frame steps, 100 discarded mixing steps and then
// KS_BITS output steps. Output bits are packed LSB first into 32-bit words
// and pushed into the FIFO. The final partial word goes in zero-padded.
//
// Ports
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   load      1-cycle start/restart pulse, samples key and frame
//   key       64-bit session key, key[i] mixed in on key step i
//   frame     22-bit frame number, frame[i] mixed in on frame step i
//   rd_en     pop the FIFO head (ignored when empty)
//   data_out  FIFO head word, 0 when empty
//   empty     FIFO holds no words (registered)
//   full      FIFO holds DEPTH words (registered)
//   busy      a generation run is in progress (registered)
// -----------------------------------------------------------------------------
module a5_keystream_buffer #(
    parameter int DEPTH   = 8,
    parameter int KS_BITS = 228
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [63:0] key,
    input  logic [21:0] frame,
    input  logic        rd_en,
    output logic [31:0] data_out,
    output logic        empty,
    output logic        full,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_FRAME,
        ST_MIX,
        ST_GEN,
        ST_DONE
    } state_t;

    // Plain LFSR shifts: new LSB is the XOR of the taps, every bit moves up one.
    function automatic logic [18:0] r1_shift(input logic [18:0] r);
        return {r[17:0], r[13] ^ r[16] ^ r[17] ^ r[18]};
    endfunction

    function automatic logic [21:0] r2_shift(input logic [21:0] r);
        return {r[20:0], r[20] ^ r[21]};
    endfunction

    function automatic logic [22:0] r3_shift(input logic [22:0] r);
        return {r[21:0], r[7] ^ r[20] ^ r[21] ^ r[22]};
    endfunction

    state_t         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [18:0]    r1_q, r1_d;
    logic [21:0]    r2_q, r2_d;
    logic [22:0]    r3_q, r3_d;
    logic [63:0]    key_q, key_d;
    logic [21:0]    frame_q, frame_d;
    logic [31:0]    acc_q, acc_d;
    logic           pend_q, pend_d;
    logic           busy_q, busy_d;

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           empty_q, empty_d;
    logic           full_q, full_d;
    logic [31:0]    mem [DEPTH];

    logic           push;
    logic           pop;
    logic           flush;
    logic [31:0]    push_word;

    logic           maj;
    logic [18:0]    r1_mc;
    logic [21:0]    r2_mc;
    logic [22:0]    r3_mc;
    logic           ks_bit;
    logic           gen_stall;

    assign pop = rd_en && !empty_q;

    // Majority-clocked versions of the three registers, shared by MIX and GEN.
    always_comb begin
        maj   = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);
        r1_mc = (r1_q[8]  == maj) ? r1_shift(r1_q) : r1_q;
        r2_mc = (r2_q[10] == maj) ? r2_shift(r2_q) : r2_q;
        r3_mc = (r3_q[10] == maj) ? r3_shift(r3_q) : r3_q;
        ks_bit = r1_mc[18] ^ r2_mc[21] ^ r3_mc[22];
    end

    // A completed word waiting for FIFO space blocks further generation, so the
    // LFSRs never run ahead of what the FIFO can absorb.
    assign gen_stall = pend_q && full_q && !rd_en;

    // Generator sequencing. A load always wins: it restarts the schedule with
    // fresh shadow copies of key/frame and, if a run was active, flushes the FIFO.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r1_d      = r1_q;
        r2_d      = r2_q;
        r3_d      = r3_q;
        key_d     = key_q;
        frame_d   = frame_q;
        acc_d     = acc_q;
        pend_d    = pend_q;
        push      = 1'b0;
        flush     = 1'b0;
        push_word = acc_q;

        if (load) begin
            state_d = ST_KEY;
            cnt_d   = '0;
            r1_d    = '0;
            r2_d    = '0;
            r3_d    = '0;
            key_d   = key;
            frame_d = frame;
            acc_d   = '0;
            pend_d  = 1'b0;
            flush   = (state_q != ST_IDLE);
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end

                ST_KEY: begin
                    r1_d = r1_shift(r1_q) ^ {18'b0, key_q[cnt_q[5:0]]};
                    r2_d = r2_shift(r2_q) ^ {21'b0, key_q[cnt_q[5:0]]};
                    r3_d = r3_shift(r3_q) ^ {22'b0, key_q[cnt_q[5:0]]};
                    if (cnt_q == 16'd63) begin
                        state_d = ST_FRAME;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end

                ST_FRAME: begin
                    r1_d = r1_shift(r1_q) ^ {18'b0, frame_q[cnt_q[4:0]]};
                    r2_d = r2_shift(r2_q) ^ {21'b0, frame_q[cnt_q[4:0]]};
                    r3_d = r3_shift(r3_q) ^ {22'b0, frame_q[cnt_q[4:0]]};
                    if (cnt_q == 16'd21) begin
                        state_d = ST_MIX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end

                ST_MIX: begin
                    r1_d = r1_mc;
                    r2_d = r2_mc;
                    r3_d = r3_mc;
                    if (cnt_q == 16'd99) begin
                        state_d = ST_GEN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end

                ST_GEN: begin
                    if (!gen_stall) begin
                        // The previous word (if any) leaves in the same cycle the
                        // first bit of the next word is produced.
                        push   = pend_q;
                        pend_d = 1'b0;
                        r1_d   = r1_mc;
                        r2_d   = r2_mc;
                        r3_d   = r3_mc;
                        if (cnt_q[4:0] == 5'd0) begin
                            acc_d = {31'b0, ks_bit};
                        end else begin
                            acc_d = acc_q | ({31'b0, ks_bit} << cnt_q[4:0]);
                        end
                        if (cnt_q[4:0] == 5'd31) begin
                            pend_d = 1'b1;
                        end
                        if (cnt_q == 16'(KS_BITS - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end

                ST_DONE: begin
                    // Final (possibly partial) word; unused upper bits are still
                    // zero because the accumulator is cleared at each word start.
                    if (!full_q || pop) begin
                        push    = 1'b1;
                        pend_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // FIFO bookkeeping. Flags are registered from the next count so they
    // change on the same edge as the count itself.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    // State registers; everything observable returns to idle values on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            r1_q     <= '0;
            r2_q     <= '0;
            r3_q     <= '0;
            key_q    <= '0;
            frame_q  <= '0;
            acc_q    <= '0;
            pend_q   <= 1'b0;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            r3_q     <= r3_d;
            key_q    <= key_d;
            frame_q  <= frame_d;
            acc_q    <= acc_d;
            pend_q   <= pend_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Word storage needs no reset: data_out is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    assign data_out = empty_q ? 32'd0 : mem[rd_ptr_q];
    assign empty    = empty_q;
    assign full     = full_q;
    assign busy     = busy_q;

endmodule
